grf_wb_arbiter: RTL and testbench

Owns the single GRF write port and shares it between two writers.
- Port A: pipeline writeback stage. Fixed priority, never back-pressured.
- Port B: long-latency units (MDU result, late loads) via a valid/ready handshake into a small FIFO.
- Drains B entries into free write slots. If B starves, raises Stall so the pipeline frees a slot.
- Sits between W-stage/MDU and grf; drives grf's RegWrite/WA/WD/PC inputs.

---
 rtl/grf_pkg.sv | 12 +
 rtl/grf_wb_fifo.sv | 35 +++
 rtl/grf_wb_arbiter.sv | 57 +++++
 tb/tb_grf_wb_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// grf_pkg: shared GRF widths and the packed write-request type used by grf, the W stage and the writeback arbiter.
package grf_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  localparam int PC_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [REG_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wreq_t;
endpackage

// File: rtl/grf_wb_fifo.sv
// grf_wb_fifo: DEPTH-entry synchronous FIFO of GRF write requests, synchronous active-low Reset.
module grf_wb_fifo import grf_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic push,
  input  logic pop,
  input  wreq_t din,
  output wreq_t head,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  wreq_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge Clk)
    if (push) mem[wr] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge Clk)
    if (!Reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  assign head = mem[rd];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the GRF write port between the W stage (priority) and a FIFO of late results.
// Define GRF_WB_TRACE_EN to print one trace line per issued architectural write.
module grf_wb_arbiter import grf_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic A_We,
  input  logic [REG_W-1:0] A_WA,
  input  logic [DATA_W-1:0] A_WD,
  input  logic [PC_W-1:0] A_PC,
  input  logic B_Valid,
  output logic B_Ready,
  input  logic [REG_W-1:0] B_WA,
  input  logic [DATA_W-1:0] B_WD,
  input  logic [PC_W-1:0] B_PC,
  output logic Stall,
  output logic RegWrite,
  output logic [REG_W-1:0] WA,
  output logic [DATA_W-1:0] WD,
  output logic [PC_W-1:0] PC,
  output logic [$clog2(DEPTH):0] B_Count
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic a_req, push, pop, issue, full, empty;
  logic [WW-1:0] wait_cnt;
  wreq_t head, iss;
  assign a_req = A_We && A_WA != REG_ZERO;
  assign B_Ready = Reset && !full;
  assign push = B_Valid && B_Ready && B_WA != REG_ZERO;
  assign pop = !a_req && !empty;
  assign issue = a_req || !empty;
  assign iss = a_req ? wreq_t'{pc: A_PC, wa: A_WA, wd: A_WD} : head;
  assign Stall = wait_cnt == WW'(MAX_WAIT);
  grf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk(Clk), .Reset(Reset), .push(push), .pop(pop), .din(wreq_t'{pc: B_PC, wa: B_WA, wd: B_WD}),
    .head(head), .count(B_Count), .full(full), .empty(empty)
  );
  always_ff @(posedge Clk)
    if (!Reset) begin
      RegWrite <= 1'b0;
      WA <= '0;
      WD <= '0;
      PC <= '0;
      wait_cnt <= '0;
    end else begin
      RegWrite <= issue;
      if (issue) {PC, WA, WD} <= iss;
      wait_cnt <= (empty || pop) ? '0 : Stall ? wait_cnt : wait_cnt + 1'b1;
    end
`ifdef GRF_WB_TRACE_EN
  always_ff @(posedge Clk)
    if (Reset && issue) $display("@%h: $%d <= %h", iss.pc, iss.wa, iss.wd);
`else
`endif
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter: table-driven directed check of the GRF writeback arbiter plus reset sequences.
module tb_grf_wb_arbiter;
  logic Clk = 1'b0, Reset = 1'b0;
  logic A_We = 1'b0, B_Valid = 1'b0;
  logic [4:0] A_WA = '0, B_WA = '0;
  logic [31:0] A_WD = '0, A_PC = '0, B_WD = '0, B_PC = '0;
  logic B_Ready, Stall, RegWrite;
  logic [4:0] WA;
  logic [31:0] WD, PC;
  logic [2:0] B_Count;
  int errors = 0, checks = 0;
  typedef struct {
    logic a_we; logic [4:0] a_wa; logic [31:0] a_wd, a_pc;
    logic b_v; logic [4:0] b_wa; logic [31:0] b_wd;
    logic rw; logic [4:0] wa; logic [31:0] wd, pc;
    logic [2:0] cnt; logic rdy, st;
  } vec_t;
  vec_t v [22];
  always #5 Clk = ~Clk;
  grf_wb_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
    .Clk(Clk), .Reset(Reset), .A_We(A_We), .A_WA(A_WA), .A_WD(A_WD), .A_PC(A_PC),
    .B_Valid(B_Valid), .B_Ready(B_Ready), .B_WA(B_WA), .B_WD(B_WD), .B_PC(B_PC),
    .Stall(Stall), .RegWrite(RegWrite), .WA(WA), .WD(WD), .PC(PC), .B_Count(B_Count)
  );
  function automatic vec_t mk(logic a_we, logic [4:0] a_wa, logic [31:0] a_wd, logic [31:0] a_pc,
                              logic b_v, logic [4:0] b_wa, logic [31:0] b_wd,
                              logic rw, logic [4:0] wa, logic [31:0] wd, logic [31:0] pc,
                              logic [2:0] cnt, logic rdy, logic st);
    vec_t r;
    r = '{a_we, a_wa, a_wd, a_pc, b_v, b_wa, b_wd, rw, wa, wd, pc, cnt, rdy, st};
    return r;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(logic a_we, logic [4:0] a_wa, logic [31:0] a_wd, logic [31:0] a_pc,
                       logic b_v, logic [4:0] b_wa, logic [31:0] b_wd);
    A_We = a_we; A_WA = a_wa; A_WD = a_wd; A_PC = a_pc;
    B_Valid = b_v; B_WA = b_wa; B_WD = b_wd; B_PC = 32'h5000 | {27'd0, b_wa};
  endtask
  // A write to $0 must never reach the register file
  always @(negedge Clk)
    if (Reset === 1'b1 && RegWrite === 1'b1) begin
      checks++;
      if (WA == 5'd0) begin
        errors++;
        $display("FAIL zero_write: got WA=%0d expected nonzero", WA);
      end
    end
  initial begin
    v[0]  = mk(1, 8,  32'h1234, 32'h3000, 0, 0, 0,           1, 8,  32'h1234, 32'h3000, 0, 1, 0);
    v[1]  = mk(0, 0,  0,        0,        1, 9, 32'hABCD,    0, 8,  32'h1234, 32'h3000, 1, 1, 0);
    v[2]  = mk(0, 0,  0,        0,        0, 0, 0,           1, 9,  32'hABCD, 32'h5009, 0, 1, 0);
    v[3]  = mk(0, 0,  0,        0,        0, 0, 0,           0, 9,  32'hABCD, 32'h5009, 0, 1, 0);
    v[4]  = mk(1, 10, 32'h10,   32'h3010, 1, 1, 32'hB1,      1, 10, 32'h10,   32'h3010, 1, 1, 0);
    v[5]  = mk(1, 11, 32'h11,   32'h3011, 1, 2, 32'hB2,      1, 11, 32'h11,   32'h3011, 2, 1, 0);
    v[6]  = mk(1, 12, 32'h12,   32'h3012, 1, 0, 32'hDEAD,    1, 12, 32'h12,   32'h3012, 2, 1, 0);
    v[7]  = mk(1, 13, 32'h13,   32'h3013, 1, 3, 32'hB3,      1, 13, 32'h13,   32'h3013, 3, 1, 0);
    v[8]  = mk(1, 14, 32'h14,   32'h3014, 1, 4, 32'hB4,      1, 14, 32'h14,   32'h3014, 4, 0, 0);
    v[9]  = mk(1, 15, 32'h15,   32'h3015, 1, 5, 32'hB5,      1, 15, 32'h15,   32'h3015, 4, 0, 0);
    v[10] = mk(1, 16, 32'h16,   32'h3016, 0, 0, 0,           1, 16, 32'h16,   32'h3016, 4, 0, 0);
    v[11] = mk(1, 17, 32'h17,   32'h3017, 0, 0, 0,           1, 17, 32'h17,   32'h3017, 4, 0, 0);
    v[12] = mk(1, 18, 32'h18,   32'h3018, 0, 0, 0,           1, 18, 32'h18,   32'h3018, 4, 0, 1);
    v[13] = mk(1, 19, 32'h19,   32'h3019, 0, 0, 0,           1, 19, 32'h19,   32'h3019, 4, 0, 1);
    v[14] = mk(0, 0,  0,        0,        1, 5, 32'hB5,      1, 1,  32'hB1,   32'h5001, 3, 1, 0);
    v[15] = mk(1, 0,  32'hFFFF, 32'h3FFF, 0, 0, 0,           1, 2,  32'hB2,   32'h5002, 2, 1, 0);
    v[16] = mk(1, 0,  32'hFFFF, 32'h3FFF, 0, 0, 0,           1, 3,  32'hB3,   32'h5003, 1, 1, 0);
    v[17] = mk(0, 0,  0,        0,        0, 0, 0,           1, 4,  32'hB4,   32'h5004, 0, 1, 0);
    v[18] = mk(0, 0,  0,        0,        0, 0, 0,           0, 4,  32'hB4,   32'h5004, 0, 1, 0);
    v[19] = mk(0, 0,  0,        0,        1, 6, 32'hB6,      0, 4,  32'hB4,   32'h5004, 1, 1, 0);
    v[20] = mk(0, 0,  0,        0,        1, 7, 32'hB7,      1, 6,  32'hB6,   32'h5006, 1, 1, 0);
    v[21] = mk(0, 0,  0,        0,        0, 0, 0,           1, 7,  32'hB7,   32'h5007, 0, 1, 0);
    drive(1, 8, 32'h77, 32'h3000, 1, 5, 32'h55);
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk); #1;
      chk("rst_ready", B_Ready, 0);
      chk("rst_regwrite", RegWrite, 0);
      chk("rst_count", B_Count, 0);
      chk("rst_stall", Stall, 0);
    end
    chk("rst_wa", WA, 0);
    chk("rst_wd", WD, 0);
    chk("rst_pc", PC, 0);
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk("rel_ready", B_Ready, 1);
    for (int i = 0; i < 22; i++) begin
      @(negedge Clk);
      drive(v[i].a_we, v[i].a_wa, v[i].a_wd, v[i].a_pc, v[i].b_v, v[i].b_wa, v[i].b_wd);
      @(posedge Clk); #1;
      chk($sformatf("v%0d_regwrite", i), RegWrite, v[i].rw);
      chk($sformatf("v%0d_wa", i), WA, v[i].wa);
      chk($sformatf("v%0d_wd", i), WD, v[i].wd);
      chk($sformatf("v%0d_pc", i), PC, v[i].pc);
      chk($sformatf("v%0d_count", i), B_Count, v[i].cnt);
      chk($sformatf("v%0d_ready", i), B_Ready, v[i].rdy);
      chk($sformatf("v%0d_stall", i), Stall, v[i].st);
    end
    // reset with a pending entry discards it and issues nothing
    @(negedge Clk);
    drive(0, 0, 0, 0, 1, 9, 32'h99);
    @(posedge Clk); #1;
    chk("mid_push_count", B_Count, 1);
    @(negedge Clk);
    drive(1, 8, 32'h88, 32'h3008, 1, 10, 32'hAA);
    Reset = 1'b0;
    @(posedge Clk); #1;
    chk("mid_rst_regwrite", RegWrite, 0);
    chk("mid_rst_count", B_Count, 0);
    chk("mid_rst_wa", WA, 0);
    chk("mid_rst_ready", B_Ready, 0);
    @(negedge Clk);
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    chk("post_rst_regwrite", RegWrite, 0);
    chk("post_rst_count", B_Count, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
